debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent switch channels, legal range 1..16.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1_000_000: consecutive cycles a synchronised input must differ before the debounced level changes; minimum 2.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25_000_000: cycles from the initial rise pulse to the first auto-repeat pulse; minimum 1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5_000_000: cycles between successive auto-repeat pulses; minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port sw_in, input, CHANNELS bits: raw asynchronous switch levels.
REQ-008 SHALL have port repeat_en, input, CHANNELS bits: per-channel auto-repeat enable, sampled on clk.
REQ-009 SHALL have port level_out, output, CHANNELS bits: debounced level, replacing the reset-style debouncer.
REQ-010 SHALL have port rise_pulse, output, CHANNELS bits: one-cycle step pulse on each debounced rise and each auto-repeat, replacing the clock-step debouncer.
REQ-011 SHALL have port fall_pulse, output, CHANNELS bits: one-cycle pulse on each debounced fall.
REQ-012 SHALL have port busy, output, CHANNELS bits: high while the channel's stability counter is non-zero.

Function
REQ-013 SHALL pass each sw_in bit through a two-flop synchroniser before any other use.
REQ-014 SHALL, per channel, clear the stability counter in any cycle where the synchronised value equals level_out, and increment it otherwise.
REQ-015 SHALL toggle level_out and clear the counter on the edge where the synchronised value has differed for STABLE_CYCLES consecutive cycles, so a clean sw_in change is reflected STABLE_CYCLES+2 edges later.
REQ-016 SHALL never change level_out when a disagreement lasts fewer than STABLE_CYCLES cycles.
REQ-017 SHALL register rise_pulse and fall_pulse at the same edge that level_out changes; each pulse is exactly one cycle wide.
REQ-018 SHALL run a per-channel repeat FSM with states IDLE, DELAY and REPEAT.
REQ-019 SHALL make the IDLE->DELAY transition on a debounced rise while repeat_en=1, clearing the repeat counter.
REQ-020 SHALL, in DELAY, pulse rise_pulse and enter REPEAT after REPEAT_DELAY cycles.
REQ-021 SHALL, in REPEAT, pulse rise_pulse every REPEAT_PERIOD cycles.
REQ-022 SHALL return the FSM to IDLE from any state on a debounced fall or on repeat_en=0, with no further repeat pulses and the repeat counter cleared.
REQ-023 SHALL keep channels fully independent, so pulses on several channels in the same cycle are legal.
REQ-024 SHALL size counters to hold the largest of STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD, with no wrap-around: counters saturate at their terminal value.

Reset
REQ-025 SHALL, while reset=1, force synchronisers, level_out, rise_pulse, fall_pulse, busy and all counters to 0 and all FSMs to IDLE, independent of clk.
REQ-026 SHALL discard any debounce or repeat in progress when reset asserts, and SHALL NOT emit a pulse for it.
REQ-027 SHALL, after reset release with sw_in high, debounce that level as a normal rise: level_out goes high and rise_pulse fires after STABLE_CYCLES+2 edges.

Structure
REQ-028 SHALL place the default cycle counts (20 ms, 500 ms and 100 ms at 50 MHz) and the FSM state encoding in shared package debounce_pkg.
REQ-029 SHALL implement one channel as sub-module debounce_channel, instantiated CHANNELS times by generate.

Verification (CHANNELS=4, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; times in edges after the stimulus edge)
REQ-030 SHALL cover clean press: sw_in[0] 0->1 at t0 with repeat_en=0 -> level_out[0]=1 and a one-cycle rise_pulse[0] at t6; busy[0] high from t3 to t5.
REQ-031 SHALL cover glitch: sw_in[1] high for 3 cycles -> level_out[1] stays 0, no pulses, busy[1] returns to 0.
REQ-032 SHALL cover auto-repeat: sw_in[2] held with repeat_en[2]=1 -> rise pulses at t6, t16, t19 and t22; release -> fall_pulse[2] at release+6 and no further rise pulses.
REQ-033 SHALL cover repeat_en drop: repeat_en[2] cleared at t17 -> no pulse at t19 or later while level_out[2] stays 1.
REQ-034 SHALL cover reset mid-count: reset at t3 -> all outputs 0 immediately; sw_in low at release -> no pulses.
REQ-035 SHALL cover simultaneous press: sw_in 4'b0000->4'b1111 at t0 -> rise_pulse=4'b1111 in the single cycle t6.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and repeat-FSM encoding for the switch debounce bank.
// Default cycle counts assume a 50 MHz clock.
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DELAY  = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD = 5_000_000;   // 100 ms

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter and
// auto-repeat FSM producing a debounced level plus rise/fall pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    input  logic repeat_en,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int MAX_CNT = max3(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lim);
        return (c >= lim) ? c : c + 1'b1;
    endfunction

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic [CNT_W-1:0] r_stab_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    rpt_state_t       r_state;

    logic             w_differ;
    logic             w_settle;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_rpt_last;
    logic             w_rpt_fire;

    assign w_differ   = r_sync_p1 ^ r_level;
    assign w_settle   = w_differ && (r_stab_cnt == STABLE_LAST);
    assign w_rise     = w_settle & r_sync_p1;
    assign w_fall     = w_settle & ~r_sync_p1;
    assign w_rpt_last = (r_state == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST;
    // A debounced fall or a dropped enable wins over a due repeat pulse.
    assign w_rpt_fire = repeat_en && !w_fall && (r_state != RPT_IDLE) &&
                        (r_rpt_cnt == w_rpt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_p0  <= 1'b0;
            r_sync_p1  <= 1'b0;
            r_stab_cnt <= '0;
            r_rpt_cnt  <= '0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_state    <= RPT_IDLE;
        end else begin
            r_sync_p0 <= sw_in;
            r_sync_p1 <= r_sync_p0;

            if (!w_differ || w_settle) r_stab_cnt <= '0;
            else                       r_stab_cnt <= sat_inc(r_stab_cnt, STABLE_LAST);

            if (w_settle) r_level <= ~r_level;
            r_rise <= w_rise | w_rpt_fire;
            r_fall <= w_fall;

            case (r_state)
                RPT_IDLE: begin
                    r_rpt_cnt <= '0;
                    if (w_rise && repeat_en) r_state <= RPT_DELAY;
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (w_fall || !repeat_en) begin
                        r_state   <= RPT_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (w_rpt_fire) begin
                        r_state   <= RPT_REPEAT;
                        r_rpt_cnt <= '0;
                    end else begin
                        r_rpt_cnt <= sat_inc(r_rpt_cnt, w_rpt_last);
                    end
                end
                default: begin
                    r_state   <= RPT_IDLE;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = |r_stab_cnt;

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent switch debouncers with per-channel
// auto-repeat on the rise pulse.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] busy
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .sw_in      (sw_in[g]),
            .repeat_en  (repeat_en[g]),
            .level_out  (level_out[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g]),
            .busy       (busy[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with short cycle counts; expected
// values are hand-derived edge numbers after each stimulus edge.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] sw_in;
    logic [CH-1:0] repeat_en;
    logic [CH-1:0] level_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;

    debounce_bank #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .repeat_en  (repeat_en),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " level"}, 32'(level_out), 32'(0));
        check({tag, " rise"},  32'(rise_pulse), 32'(0));
        check({tag, " fall"},  32'(fall_pulse), 32'(0));
        check({tag, " busy"},  32'(busy), 32'(0));
    endtask

    initial begin
        reset     = 1'b1;
        sw_in     = '0;
        repeat_en = '0;
        #12;
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        // Clean press and release on channel 0, no repeat.
        sw_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("press0 t%0d level", k), 32'(level_out[0]), 32'(k >= 6));
            check($sformatf("press0 t%0d rise", k), 32'(rise_pulse[0]), 32'(k == 6));
            check($sformatf("press0 t%0d busy", k), 32'(busy[0]), 32'(k >= 3 && k <= 5));
            check($sformatf("press0 t%0d fall", k), 32'(fall_pulse[0]), 32'(0));
        end
        sw_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("rel0 t%0d level", k), 32'(level_out[0]), 32'(k < 6));
            check($sformatf("rel0 t%0d fall", k), 32'(fall_pulse[0]), 32'(k == 6));
            check($sformatf("rel0 t%0d rise", k), 32'(rise_pulse[0]), 32'(0));
            check($sformatf("rel0 t%0d busy", k), 32'(busy[0]), 32'(k >= 3 && k <= 5));
        end

        // Three-cycle glitch on channel 1.
        sw_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) sw_in[1] = 1'b0;
            check($sformatf("glitch1 t%0d level", k), 32'(level_out[1]), 32'(0));
            check($sformatf("glitch1 t%0d pulses", k), 32'({rise_pulse[1], fall_pulse[1]}), 32'(0));
            check($sformatf("glitch1 t%0d busy", k), 32'(busy[1]), 32'(k >= 3 && k <= 5));
        end

        // Auto-repeat on channel 2, released after edge 23 (fall at 29).
        repeat_en[2] = 1'b1;
        sw_in[2]     = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 23) sw_in[2] = 1'b0;
            check($sformatf("rpt2 t%0d level", k), 32'(level_out[2]), 32'(k >= 6 && k < 29));
            check($sformatf("rpt2 t%0d fall", k), 32'(fall_pulse[2]), 32'(k == 29));
            if (k <= 23 || k >= 29)
                check($sformatf("rpt2 t%0d rise", k), 32'(rise_pulse[2]),
                      32'(k == 6 || k == 16 || k == 19 || k == 22));
        end

        // repeat_en dropped at t17 on channel 2.
        sw_in[2] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 17) repeat_en[2] = 1'b0;
            check($sformatf("endrop2 t%0d level", k), 32'(level_out[2]), 32'(k >= 6));
            check($sformatf("endrop2 t%0d rise", k), 32'(rise_pulse[2]), 32'(k == 6 || k == 16));
        end
        sw_in[2] = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        check("endrop2 released level", 32'(level_out), 32'(0));

        // Simultaneous press on all channels.
        sw_in = 4'b1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("simul t%0d rise", k), 32'(rise_pulse), 32'(k == 6 ? 4'b1111 : 4'b0000));
        end
        check("simul level", 32'(level_out), 32'(4'b1111));

        // Reset in the middle of a fall debounce on channel 3.
        sw_in[3] = 1'b0;
        tick();
        tick();
        tick();
        check("midrst busy3 before", 32'(busy[3]), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst async");
        sw_in = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("midrst t%0d outputs", k),
                  32'({level_out, rise_pulse, fall_pulse, busy}), 32'(0));
        end

        // Reset released with sw_in[0] already high.
        reset = 1'b1;
        sw_in = 4'b0001;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("relhigh t%0d rise", k), 32'(rise_pulse), 32'(k == 6 ? 4'b0001 : 4'b0000));
            check($sformatf("relhigh t%0d level", k), 32'(level_out), 32'(k >= 6 ? 4'b0001 : 4'b0000));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
